// File: rtl/vend_dispense_ctrl.sv
// Vending machine dispense controller.
// Accepts a vend request, checks per-product stock, drives the product motor
// for a fixed time, returns change as a train of 5-unit coin pulses and then
// strobes completion. A sold-out product skips straight to completion with a
// refund strobe. Stock counters are reloaded by reset or a restock pulse.
module vend_dispense_ctrl #(
  parameter int MOTOR_CYCLES = 4,
  parameter int COIN_CYCLES  = 2,
  parameter int STOCK_MAX    = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vend_req,
  input  logic [1:0] vend_prod,
  input  logic [2:0] vend_change,
  input  logic       restock,
  input  logic [1:0] restock_prod,
  output logic [3:0] motor,
  output logic       coin_eject,
  output logic       vend_ack,
  output logic       refund,
  output logic       busy,
  output logic [3:0] sold_out
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MOTOR,
    CHANGE,
    DONE
  } state_t;

  localparam logic [3:0] MOTOR_LOAD = 4'(MOTOR_CYCLES - 1);
  localparam logic [3:0] COIN_LOAD  = 4'(COIN_CYCLES - 1);
  localparam logic [3:0] STOCK_LOAD = 4'(STOCK_MAX);

  state_t     state;
  logic [1:0] prod;
  logic [1:0] coins;
  logic [3:0] cnt;
  logic [3:0] stock [4];
  logic       cur_empty;

  // Only one-hot change codes are meaningful; anything else returns no coins.
  function automatic logic [1:0] coin_count(input logic [2:0] code);
    case (code)
      3'b001:  coin_count = 2'd1;
      3'b010:  coin_count = 2'd2;
      3'b100:  coin_count = 2'd3;
      default: coin_count = 2'd0;
    endcase
  endfunction

  assign cur_empty = (stock[prod] == 4'd0);
  assign busy      = (state != IDLE);

  // Dispense sequencer: state, captured transaction and all strobe outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prod       <= 2'd0;
      coins      <= 2'd0;
      cnt        <= 4'd0;
      motor      <= 4'b0000;
      coin_eject <= 1'b0;
      vend_ack   <= 1'b0;
      refund     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (vend_req) begin
            prod  <= vend_prod;
            coins <= coin_count(vend_change);
            state <= CHECK;
          end
        end
        CHECK: begin
          if (cur_empty) begin
            vend_ack <= 1'b1;
            refund   <= 1'b1;
            state    <= DONE;
          end else begin
            motor <= 4'b0001 << prod;
            cnt   <= MOTOR_LOAD;
            state <= MOTOR;
          end
        end
        MOTOR: begin
          if (cnt == 4'd0) begin
            motor <= 4'b0000;
            if (coins != 2'd0) begin
              coin_eject <= 1'b1;
              cnt        <= COIN_LOAD;
              state      <= CHANGE;
            end else begin
              vend_ack <= 1'b1;
              state    <= DONE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        CHANGE: begin
          if (coin_eject) begin
            if (cnt == 4'd0) begin
              coin_eject <= 1'b0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end else begin
            coins <= coins - 2'd1;
            if (coins == 2'd1) begin
              vend_ack <= 1'b1;
              state    <= DONE;
            end else begin
              coin_eject <= 1'b1;
              cnt        <= COIN_LOAD;
            end
          end
        end
        DONE: begin
          vend_ack <= 1'b0;
          refund   <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stock counters: restock reloads and wins over a same-cycle decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        stock[i] <= STOCK_LOAD;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (restock && (restock_prod == 2'(i))) begin
          stock[i] <= STOCK_LOAD;
        end else if ((state == CHECK) && (prod == 2'(i)) && (stock[i] != 4'd0)) begin
          stock[i] <= stock[i] - 4'd1;
        end
      end
    end
  end

  // Sold-out flags decoded straight from the stock registers.
  always_comb begin
    sold_out = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      sold_out[i] = (stock[i] == 4'd0);
    end
  end

endmodule

// File: doc/vend_dispense_ctrl.md
VEND_DISPENSE_CTRL -- requirements
Module: vend_dispense_ctrl

Interface
REQ-001 Parameter MOTOR_CYCLES, default 4: cycles motor line held high per dispense, legal range 1..15.
REQ-002 Parameter COIN_CYCLES, default 2: high time in cycles of each coin_eject pulse, legal range 1..7.
REQ-003 Parameter STOCK_MAX, default 9: per-product stock value loaded by reset and restock, legal range 1..15.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 vend_req  in  1  single-cycle vend request pulse from vending FSM.
REQ-007 vend_prod  in  2  product code (00=A, 01=B, 10=C, 11=D), valid with vend_req.
REQ-008 vend_change  in  3  change code (000=none, 001=5, 010=10, 100=15), valid with vend_req.
REQ-009 restock  in  1  single-cycle restock pulse.
REQ-010 restock_prod  in  2  product to restock, valid with restock.
REQ-011 motor  out  4  one-hot dispense motor drive, bit i = product i.
REQ-012 coin_eject  out  1  one pulse per 5-unit coin returned.
REQ-013 vend_ack  out  1  one-cycle completion strobe.
REQ-014 refund  out  1  one-cycle sold-out strobe, coincident with vend_ack.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 sold_out  out  4  bit i high when stock of product i is 0.

Function
REQ-017 FSM states SHALL be IDLE, CHECK, MOTOR, CHANGE, DONE; all outputs registered or decoded from registered state only.
REQ-018 IDLE: vend_req=1 -> capture vend_prod and coin count, go to CHECK; vend_req while busy=1 is dropped, no side effect.
REQ-019 Coin count: 000->0, 001->1, 010->2, 100->3; any non-one-hot code -> 0.
REQ-020 CHECK (1 cycle): stock[prod]==0 -> DONE with refund; else decrement stock[prod], go to MOTOR.
REQ-021 MOTOR: motor[prod]=1 for exactly MOTOR_CYCLES cycles, then CHANGE if count>0, else DONE.
REQ-022 CHANGE: per coin, coin_eject high COIN_CYCLES cycles then low 1 cycle; after last coin's low cycle -> DONE.
REQ-023 DONE (1 cycle): vend_ack=1, refund=1 only on sold-out path, then IDLE; vend_req in DONE is dropped.
REQ-024 Stock: four 4-bit counters, never below 0, never above STOCK_MAX.
REQ-025 restock=1 loads stock[restock_prod]=STOCK_MAX in any state, effective next cycle.
REQ-026 Restock and CHECK decrement on same product same cycle: restock wins, stock=STOCK_MAX.
REQ-027 Restock during MOTOR/CHANGE of same product does not abort or alter the dispense in progress.
REQ-028 motor SHALL never have more than one bit set; motor and coin_eject never high together.
REQ-029 sold_out reflects counter value with no extra latency beyond the counter register.

Reset
REQ-030 rst_n=0 forces asynchronously: state=IDLE, motor=0000, coin_eject=0, vend_ack=0, refund=0, busy=0.
REQ-031 rst_n=0 loads all four stock counters with STOCK_MAX, sold_out=0000.
REQ-032 Reset mid-dispense abandons the transaction: no vend_ack, no change completion, stock left at STOCK_MAX.

Verification
REQ-033 Defaults, vend_req at cycle 0, prod=01, change=010 -> motor=0010 cycles 2-5, coin_eject high 6-7 and 9-10, vend_ack at 12, stock B 9->8.
REQ-034 Defaults, prod=11, change=000 -> motor=1000 cycles 2-5, no coin_eject, vend_ack at 6, refund=0.
REQ-035 Nine vends of product A, then tenth -> sold_out=0001 after ninth; tenth: no motor, vend_ack and refund both high at cycle 2.
REQ-036 Sold-out A, restock pulse prod=00 -> sold_out[0]=0 next cycle, stock A=9; following vend dispenses normally.
REQ-037 vend_req pulses during MOTOR and DONE -> ignored, exactly one vend_ack, stock decremented once.
REQ-038 rst_n low during CHANGE -> motor and coin_eject drop immediately, busy=0, no vend_ack, all stock=9.
